// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared 2-bit counter encodings for the branch predictor
// Purpose: counter type, the four saturating-counter states and the table reset value.
// Ports: none (package).
package branch_predictor_pkg;

  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t BP_SNT   = 2'b00;  // strongly not-taken
  localparam bp_ctr_t BP_WNT   = 2'b01;  // weakly not-taken
  localparam bp_ctr_t BP_WT    = 2'b10;  // weakly taken
  localparam bp_ctr_t BP_ST    = 2'b11;  // strongly taken
  localparam bp_ctr_t BP_RESET = BP_WNT;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// rtl/branch_predictor_sat_counter2.sv - next-state function of a 2-bit saturating counter
// Purpose: purely combinational step of one counter towards taken or not-taken.
// Ports:
//   cur_state in 2 : current counter value
//   taken     in 1 : resolved direction
//   next_state out 2: counter value after the step, saturating at 00 / 11
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  bp_ctr_t cur_state,
  input  logic    taken,
  output bp_ctr_t next_state
);

  always_comb begin
    next_state = cur_state;
    if (taken) begin
      if (cur_state != BP_ST) next_state = cur_state + 2'd1;
    end else begin
      if (cur_state != BP_SNT) next_state = cur_state - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal branch direction predictor with mispredict statistics
// Purpose: flop table of 2-bit counters indexed by pc[IDX_W+1:2], combinational lookup
//          with same-cycle update bypass, mispredict flag and 32-bit statistics.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   pred_valid, pred_pc          : fetch lookup request
//   pred_taken                   : predicted direction (combinational)
//   upd_valid, upd_pc            : resolved conditional branch from execute
//   upd_taken, upd_pred          : actual outcome and the prediction made at fetch
//   mispredict                   : outcome differs from prediction (combinational)
//   stats_clr                    : clear both statistics counters
//   br_count, mispred_count      : resolved branches / mispredicts since reset or clear
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES  = 32,
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pred_valid,
  input  logic [PC_WIDTH-1:0] pred_pc,
  output logic                pred_taken,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic                upd_pred,
  output logic                mispredict,
  input  logic                stats_clr,
  output logic [31:0]         br_count,
  output logic [31:0]         mispred_count
);

  localparam int IDX_W = $clog2(ENTRIES);

  bp_ctr_t     table_q [ENTRIES];
  bp_ctr_t     table_d [ENTRIES];
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] mispred_count_q, mispred_count_d;

  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] upd_idx;
  bp_ctr_t          upd_next;

  // pred_valid only qualifies the request for the pipeline; the lookup is always live.
  // Upper and byte-offset PC bits are intentionally untagged.
  logic unused_inputs;
  assign unused_inputs = ^{pred_valid, pred_pc, upd_pc};

  assign pred_idx = pred_pc[IDX_W+1:2];
  assign upd_idx  = upd_pc[IDX_W+1:2];

  // Single next-state instance: feeds both the write port and the bypass.
  sat_counter2 u_sat_counter2 (
    .cur_state  (table_q[upd_idx]),
    .taken      (upd_taken),
    .next_state (upd_next)
  );

  assign mispredict = upd_valid & (upd_taken != upd_pred);

  // Bypass so a lookup in the training cycle sees the post-update counter.
  always_comb begin
    pred_taken = table_q[pred_idx][1];
    if (upd_valid && (upd_idx == pred_idx)) pred_taken = upd_next[1];
  end

  always_comb begin
    table_d = table_q;
    if (upd_valid) table_d[upd_idx] = upd_next;
  end

  // A clear wins over a same-cycle increment.
  always_comb begin
    br_count_d      = br_count_q + {31'd0, upd_valid};
    mispred_count_d = mispred_count_q + {31'd0, mispredict};
    if (stats_clr) begin
      br_count_d      = '0;
      mispred_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= BP_RESET;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      table_q         <= table_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_pred;
  logic        mispredict;
  logic        stats_clr;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(32), .PC_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .pred_valid    (pred_valid),
    .pred_pc       (pred_pc),
    .pred_taken    (pred_taken),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_pred      (upd_pred),
    .mispredict    (mispredict),
    .stats_clr     (stats_clr),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  // Inputs for one cycle and the outputs expected before that cycle's edge
  // (counts are the registered values going into the edge).
  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic        up;
    logic [31:0] ppc;
    logic        clr;
    logic        e_pt;
    logic        e_mp;
    logic [31:0] e_br;
    logic [31:0] e_mc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic uv, input logic [31:0] upc, input logic ut, input logic up,
                     input logic [31:0] ppc, input logic clr, input logic e_pt, input logic e_mp,
                     input logic [31:0] e_br, input logic [31:0] e_mc);
    vec_t v;
    v.uv = uv; v.upc = upc; v.ut = ut; v.up = up; v.ppc = ppc; v.clr = clr;
    v.e_pt = e_pt; v.e_mp = e_mp; v.e_br = e_br; v.e_mc = e_mc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; pred_valid = 1'b1; pred_pc = '0; upd_valid = 1'b0;
    upd_pc = '0; upd_taken = 1'b0; upd_pred = 1'b0; stats_clr = 1'b0;
  endtask

  task automatic sweep_all_nt(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      idle_inputs();
      pred_pc = 32'(i * 4);
      #1;
      check($sformatf("%s pred_taken pc=0x%0h", tag, pred_pc), {31'd0, pred_taken}, 32'd0);
    end
    check({tag, " br_count"}, br_count, 32'd0);
    check({tag, " mispred_count"}, mispred_count, 32'd0);
  endtask

  initial begin
    // 0x100, 0x180, 0x200 share index 0; 0x104, 0x204 index 1; 0x108 index 2.
    //   uv  upc       ut  up  ppc       clr pt  mp  br     mc
    add(0, 32'h100, 1, 0, 32'h100, 0, 0, 0, 32'd0,  32'd0);  // idle upd: no mispredict
    add(1, 32'h100, 1, 0, 32'h104, 0, 0, 1, 32'd0,  32'd0);  // 01->10
    add(0, 32'h100, 1, 0, 32'h100, 0, 1, 0, 32'd1,  32'd1);
    add(1, 32'h100, 1, 1, 32'h104, 0, 0, 0, 32'd1,  32'd1);  // 10->11
    add(1, 32'h100, 1, 1, 32'h104, 0, 0, 0, 32'd2,  32'd1);  // 11 saturates
    add(0, 32'h100, 0, 0, 32'h100, 0, 1, 0, 32'd3,  32'd1);
    add(1, 32'h100, 0, 1, 32'h104, 0, 0, 1, 32'd3,  32'd1);  // 11->10
    add(0, 32'h100, 0, 0, 32'h100, 0, 1, 0, 32'd4,  32'd2);
    add(1, 32'h100, 0, 1, 32'h104, 0, 0, 1, 32'd4,  32'd2);  // 10->01
    add(0, 32'h100, 0, 0, 32'h100, 0, 0, 0, 32'd5,  32'd3);
    add(1, 32'h100, 0, 0, 32'h104, 0, 0, 0, 32'd5,  32'd3);  // 01->00
    add(1, 32'h100, 0, 0, 32'h104, 0, 0, 0, 32'd6,  32'd3);  // 00 saturates
    add(1, 32'h100, 1, 0, 32'h100, 0, 0, 1, 32'd7,  32'd3);  // bypass 00->01, msb 0
    add(0, 32'h100, 0, 0, 32'h100, 0, 0, 0, 32'd8,  32'd4);
    add(1, 32'h100, 1, 0, 32'h104, 0, 0, 1, 32'd8,  32'd4);  // 01->10
    add(1, 32'h100, 1, 1, 32'h104, 0, 0, 0, 32'd9,  32'd5);  // 10->11
    add(0, 32'h100, 0, 0, 32'h180, 0, 1, 0, 32'd10, 32'd5);  // alias of 0x100
    add(0, 32'h100, 0, 0, 32'h104, 0, 0, 0, 32'd10, 32'd5);
    add(0, 32'h100, 0, 0, 32'h103, 0, 1, 0, 32'd10, 32'd5);  // byte offset ignored
    add(1, 32'h100, 0, 1, 32'h104, 0, 0, 1, 32'd10, 32'd5);  // 11->10
    add(1, 32'h100, 0, 0, 32'h104, 0, 0, 0, 32'd11, 32'd6);  // 10->01
    add(1, 32'h200, 1, 0, 32'h200, 0, 1, 1, 32'd12, 32'd6);  // bypass 01->10
    add(1, 32'h204, 0, 0, 32'h200, 0, 1, 0, 32'd13, 32'd7);  // other index, no bypass
    add(0, 32'h100, 0, 0, 32'h104, 0, 0, 0, 32'd14, 32'd7);  // idx1 now 00
    add(1, 32'h104, 1, 0, 32'h108, 1, 0, 1, 32'd14, 32'd7);  // clear beats increment
    add(0, 32'h100, 0, 0, 32'h104, 0, 0, 0, 32'd0,  32'd0);  // idx1 00->01 still trained
    add(1, 32'h104, 1, 1, 32'h104, 0, 1, 0, 32'd0,  32'd0);  // bypass 01->10
    add(0, 32'h100, 0, 0, 32'h104, 0, 1, 0, 32'd1,  32'd0);

    // Reset with a concurrent update that must be dropped.
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
    @(posedge clk);
    sweep_all_nt("reset");

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      idle_inputs();
      upd_valid = vecs[i].uv; upd_pc = vecs[i].upc; upd_taken = vecs[i].ut;
      upd_pred = vecs[i].up; pred_pc = vecs[i].ppc; stats_clr = vecs[i].clr;
      #1;
      check($sformatf("v%0d pred_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].e_pt});
      check($sformatf("v%0d mispredict", i), {31'd0, mispredict}, {31'd0, vecs[i].e_mp});
      check($sformatf("v%0d br_count", i), br_count, vecs[i].e_br);
      check($sformatf("v%0d mispred_count", i), mispred_count, vecs[i].e_mc);
    end

    // Wrap: preload both counters to all-ones, then one mispredicting update.
    @(negedge clk);
    idle_inputs();
    force dut.br_count_q = 32'hFFFF_FFFF;
    force dut.mispred_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.br_count_q;
    release dut.mispred_count_q;
    #1;
    check("preload br_count", br_count, 32'hFFFF_FFFF);
    upd_valid = 1'b1; upd_pc = 32'h10C; upd_taken = 1'b1; upd_pred = 1'b0;
    @(negedge clk);
    idle_inputs();
    #1;
    check("wrap br_count", br_count, 32'd0);
    check("wrap mispred_count", mispred_count, 32'd0);
    // One more ordinary update counts from the wrapped value.
    upd_valid = 1'b1; upd_pc = 32'h10C; upd_taken = 1'b0; upd_pred = 1'b0;
    @(negedge clk);
    idle_inputs();
    #1;
    check("post-wrap br_count", br_count, 32'd1);
    check("post-wrap mispred_count", mispred_count, 32'd0);

    // Reset during an update after training: whole table back to weakly-NT.
    @(negedge clk);
    idle_inputs();
    rst = 1'b1; upd_valid = 1'b1; upd_pc = 32'h104; upd_taken = 1'b1; upd_pred = 1'b0;
    @(posedge clk);
    sweep_all_nt("mid-reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
